sine_lut_arbiter: RTL
=====================

# sine_lut_arbiter

Round-robin arbiter that shares one registered 256-entry sine lookup table (8-bit phase in, 8-bit offset-binary sine out, one-clock registered latency) among NREQ independent requesters. Accepts at most one phase lookup per clock, drives the table's lookup input from a register, and tracks each in-flight lookup with a requester tag. Returns each result on a shared data bus with a one-hot response strobe. Sits between the oscillator/modulator channels of the DSP datapath and the single sine table instance.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  bit i: requester i holds a lookup request
- req_phase  in  8*NREQ  phase of requester i in bits [8i+7:8i]
- req_cos  in  NREQ  bit i: requester i wants cosine (used only with SINE_ARB_COS_EN)
- req_ready  out  NREQ  one-hot or zero grant; combinational from req_valid and the RR pointer
- resp_valid  out  NREQ  one-hot, one-cycle strobe: resp_data belongs to requester i
- resp_data  out  8  looked-up sine value
- lut_lookup  out  8  registered phase to the sine table lookup input
- lut_sine  in  8  sine table output

## Operation
- Arbitration: the lowest index at or after (ptr+1) mod NREQ with req_valid set is granted; req_ready has that bit set and all others clear. If no request is pending, req_ready is 0.
- Acceptance happens on the edge where req_valid[i] & req_ready[i]. On that edge:
  - lut_lookup <= phase_i, with the cosine adjustment applied only under SINE_ARB_COS_EN (see Configuration).
  - Stage-1 tag <= {valid=1, id=i}.
  - ptr <= i.
- Each edge, the stage-1 tag advances to the stage-2 tag. In the same edge, stage-2 produces resp_data <= lut_sine and resp_valid <= onehot(stage-2 id), or resp_valid <= 0 if the stage-2 tag is invalid.
- A cycle with no grant loads an invalid stage-1 tag. lut_lookup holds its previous value.
- Requesters are never back-pressured on responses. A requester must consume resp_data in the cycle resp_valid[i] is high.
- A requester may keep req_valid high across consecutive cycles. Each grant is a new lookup. A requester must not change req_phase while req_valid is high and req_ready is low.
- Phase arithmetic is 8-bit modulo 256. Wrap is silent.

## Timing
- Reset values: ptr = NREQ-1 (requester 0 wins first), both tags invalid, lut_lookup = 0, resp_valid = 0, resp_data = 0. req_ready follows req_valid combinationally, including during and right after reset deassertion.
- Latency: acceptance on edge E0 leads to lut_lookup valid after E0, the table output valid after E1, and resp_valid/resp_data valid after E2. The response is therefore visible in the second cycle after acceptance.
- Throughput is one lookup per clock. Up to two lookups are in flight.
- All NREQ requesting continuously: grants rotate 0,1,…,NREQ-1,0 with no gaps and no starvation. The maximum wait for any requester is NREQ-1 cycles.
- A single requester holding req_valid continuously is granted every cycle.
- Reset asserted mid-operation: in-flight tags are discarded and no resp_valid is issued for them. The table's own register is not reset. Its stale output is masked by the invalid tags.
- A requester dropping req_valid in the same cycle as another rises: arbitration uses only the current-cycle req_valid.

## Configuration
- SINE_ARB_COS_EN defined: when req_cos[i] is set for an accepted request, lut_lookup <= phase_i + 64 (mod 256), giving cosine.
- SINE_ARB_COS_EN undefined: req_cos is ignored, lut_lookup <= phase_i always, and no adder is present.

## Test plan
- After reset, requester 0 requests phase 0 alone → req_ready = 0001; two cycles later resp_valid = 0001 and resp_data = 127.
- Requesters 1 and 3 request phases 64 and 192 continuously → grants alternate 1,3,1,3. Responses carry 254 for requester 1 and 0 for requester 3, with resp_valid one-hot and matching each grant two cycles later.
- All four request continuously for 12 cycles → each requester is granted exactly 3 times in order 0,1,2,3. resp_valid is high every cycle from the third cycle onward.
- Reset is asserted one cycle after two accepted lookups (phases 32 and 96) → no resp_valid appears for either. After release, a new phase-32 request returns 217.
- With SINE_ARB_COS_EN, requester 2 requests phase 0 with req_cos = 1 → lut_lookup = 64 and resp_data = 254. Without the macro, the same stimulus gives lut_lookup = 0 and resp_data = 127.
- Requester 0 requests phase 255, then phase 128 back-to-back → responses 124 then 127 on consecutive cycles, with no gap.

Source files
------------

// File: rtl/sine_lut_arbiter_if.sv
// ---------------------------------------------------------------------------
// sine_lut_arbiter_if
//
// Requester-side bus of the shared sine lookup arbiter. One set of lanes per
// requester plus the shared response bus.
//
//   req_valid  [NREQ]    requester i holds a lookup request
//   req_phase  [8*NREQ]  phase of requester i in bits [8i+7:8i]
//   req_cos    [NREQ]    requester i wants cosine (honoured only when the
//                        arbiter is built with SINE_ARB_COS_EN)
//   req_ready  [NREQ]    one-hot or zero grant
//   resp_valid [NREQ]    one-hot, one-cycle response strobe
//   resp_data  [8]       looked-up sine value
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sine_lut_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_phase;
    logic [NREQ-1:0]   req_cos;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   resp_valid;
    logic [7:0]        resp_data;

    modport master (
        output req_valid, req_phase, req_cos,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_phase, req_cos,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/sine_lut_arbiter.sv
// ---------------------------------------------------------------------------
// sine_lut_arbiter
//
// Round-robin arbiter sharing one registered 256-entry sine table among NREQ
// requesters (legal range 2..8). One lookup is accepted per clock. The
// accepted phase is registered onto lut_lookup, and a requester tag follows
// the lookup through two stages. The table output is then returned on the
// shared resp_data bus with a one-hot resp_valid strobe. The response appears
// two cycles after acceptance.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   bus         sine_lut_arbiter_if.slave (request/grant/response lanes)
//   lut_lookup  registered phase driven to the sine table
//   lut_sine    sine table output (registered inside the table)
//
// Build option:
//   SINE_ARB_COS_EN  when defined, an accepted request with req_cos set
//                    looks up phase+64 (mod 256), which gives cosine. When
//                    undefined, req_cos is ignored and no adder is built.
// ---------------------------------------------------------------------------
module sine_lut_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                clk,
    input  logic                rst,
    sine_lut_arbiter_if.slave   bus,
    output logic [7:0]          lut_lookup,
    input  logic [7:0]          lut_sine
);
    localparam int IDW = $clog2(NREQ);

    // Round-robin pointer: index of the most recent grant.
    logic [IDW-1:0]  ptr;

    logic [NREQ-1:0] grant;
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic [7:0]      grant_phase;
    logic [7:0]      lookup_next;
`ifdef SINE_ARB_COS_EN
    logic            grant_cos;
`else
    // req_cos has no function in this build.
    logic            cos_unused;
    assign cos_unused = ^bus.req_cos;
`endif

    // Tags of the in-flight lookups: stage 1 lines up with lut_lookup,
    // stage 2 lines up with the table output.
    logic            s1_valid;
    logic [IDW-1:0]  s1_id;
    logic            s2_valid;
    logic [IDW-1:0]  s2_id;

    logic [NREQ-1:0] resp_valid_q;
    logic [7:0]      resp_data_q;

    // -----------------------------------------------------------------------
    // Arbitration. Search starts one past the last grant and wraps, so the
    // last winner has the lowest priority. The result is purely combinational
    // from req_valid and ptr, so it is valid during reset too.
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; a missing
    // default on any path would infer a latch.
    always_comb begin
        grant       = '0;
        grant_any   = 1'b0;
        grant_id    = '0;
        grant_phase = '0;
`ifdef SINE_ARB_COS_EN
        grant_cos   = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_any && bus.req_valid[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
                grant_phase = bus.req_phase[idx*8 +: 8];
`ifdef SINE_ARB_COS_EN
                grant_cos   = bus.req_cos[idx];
`endif
            end
        end
    end

    assign bus.req_ready = grant;

    // A quarter turn of phase (64 of 256) turns sine into cosine; wrap is
    // silent modulo 256.
`ifdef SINE_ARB_COS_EN
    assign lookup_next = grant_cos ? (grant_phase + 8'd64) : grant_phase;
`else
    assign lookup_next = grant_phase;
`endif

    // -----------------------------------------------------------------------
    // Lookup register, tag pipeline and response register.
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value (the tag pipeline relies on it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= IDW'(NREQ - 1);
            lut_lookup   <= '0;
            s1_valid     <= 1'b0;
            s1_id        <= '0;
            s2_valid     <= 1'b0;
            s2_id        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            // lut_lookup holds through idle cycles; only the tag says
            // whether the table output is meaningful.
            if (grant_any) begin
                lut_lookup <= lookup_next;
                ptr        <= grant_id;
            end

            s1_valid <= grant_any;
            s1_id    <= grant_id;
            s2_valid <= s1_valid;
            s2_id    <= s1_id;

            // NOTE: the table's own output register is never reset, so right
            // after reset lut_sine may be stale; the cleared tags keep that
            // stale value from ever being strobed.
            resp_data_q  <= lut_sine;
            resp_valid_q <= s2_valid ? (NREQ'(1) << s2_id) : '0;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;

    // -----------------------------------------------------------------------
    // Protocol properties (simulation only; ignored by synthesis).
    // -----------------------------------------------------------------------
    a_grant_onehot0 : assert property (
        @(posedge clk) disable iff (rst) $onehot0(bus.req_ready)
    );

    a_resp_onehot0 : assert property (
        @(posedge clk) disable iff (rst) $onehot0(bus.resp_valid)
    );

    a_grant_only_valid : assert property (
        @(posedge clk) disable iff (rst) ((bus.req_ready & ~bus.req_valid) == '0)
    );

    // A requester left waiting must keep its phase while it keeps asking.
    for (genvar i = 0; i < NREQ; i++) begin : g_req_prop
        a_phase_hold : assert property (
            @(posedge clk) disable iff (rst)
            (bus.req_valid[i] && !bus.req_ready[i]) |=>
                (!bus.req_valid[i] || $stable(bus.req_phase[i*8 +: 8]))
        );
    end

endmodule
